baud_tick_gen_frac: RTL

Parametrised successor to the UART tick generator. It produces an oversample tick (rx_tick) and a bit tick (tx_tick) from a programmable fixed-point divisor (integer plus fractional part), so non-integer clock/baud ratios carry no accumulated error. Configuration arrives through a valid/ready handshake and is switched glitch-free on a bit boundary. A restart input re-aligns tick phase to a receiver start-bit edge. It sits between the CSR block and the UART tx/rx engines.

---
 rtl/uart_pkg.sv | 54 +++++
 rtl/tick_frac_divider.sv | 78 +++++++
 rtl/baud_tick_gen_frac.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types and constants for the UART baud tick generator:
//             controller state encoding, reset divisor, and the baud code
//             to fixed-point divisor table used by the CSR decode.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Controller states of the tick generator.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } tick_state_e;

  // 325.5 clocks per oversample tick: 9600 baud x16 from a 50 MHz clock.
  localparam int DEF_DIV_INT  = 325;
  localparam int DEF_DIV_FRAC = 8;

  // Divisor format carried by the baud code table (12.4 fixed point).
  localparam int BR_DIV_INT_W  = 12;
  localparam int BR_DIV_FRAC_W = 4;

  typedef enum logic [2:0] {
    BR_9600   = 3'd0,
    BR_19200  = 3'd1,
    BR_38400  = 3'd2,
    BR_57600  = 3'd3,
    BR_115200 = 3'd4
  } br_code_e;

  typedef struct packed {
    logic [BR_DIV_INT_W-1:0]  div_int;
    logic [BR_DIV_FRAC_W-1:0] div_frac;
  } br_div_t;

  // Baud code to divisor for a 50 MHz clock and x16 oversampling.
  function automatic br_div_t br_decode(input br_code_e code);
    br_div_t d;
    case (code)
      BR_9600:   d = '{div_int: 12'd325, div_frac: 4'd8};   // 325.500
      BR_19200:  d = '{div_int: 12'd162, div_frac: 4'd12};  // 162.750
      BR_38400:  d = '{div_int: 12'd81,  div_frac: 4'd6};   //  81.375
      BR_57600:  d = '{div_int: 12'd54,  div_frac: 4'd4};   //  54.250
      BR_115200: d = '{div_int: 12'd27,  div_frac: 4'd2};   //  27.125
      default:   d = '{div_int: 12'd325, div_frac: 4'd8};
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_frac_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tick_frac_divider
//  Brief    : Fixed-point clock divider. Counts clocks up to the current
//             period and emits rx_tick; a fractional accumulator stretches
//             the period by one clock whenever it carries out, so the mean
//             period equals div_int + div_frac / 2^DIV_FRAC_W.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_frac_divider
  import uart_pkg::*;
#(
  parameter int DIV_INT_W  = 12,
  parameter int DIV_FRAC_W = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  run_i,
  input  logic                  load_i,
  input  logic [DIV_INT_W-1:0]  div_int_i,
  input  logic [DIV_FRAC_W-1:0] div_frac_i,
  output logic                  rx_tick_o
);

  localparam logic [DIV_INT_W:0] C_ONE = {{DIV_INT_W{1'b0}}, 1'b1};

  // One extra bit so a stretched period of div_int+1 cannot overflow.
  logic [DIV_INT_W:0]  cnt_q, cnt_d;
  logic [DIV_FRAC_W-1:0] acc_q, acc_d;
  logic                carry_q, carry_d;
  logic [DIV_INT_W:0]  period;
  logic [DIV_INT_W:0]  last;
  logic [DIV_FRAC_W:0] acc_sum;
  logic                match;

  assign period  = {1'b0, div_int_i} + {{DIV_INT_W{1'b0}}, carry_q};
  assign last    = period - C_ONE;
  assign match   = (cnt_q == last);
  assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac_i};

  // Tick is a decode of the registered count; run_i is itself registered.
  assign rx_tick_o = run_i & match;

  // Next count / accumulator: clear on load, wrap and accumulate on a tick.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    if (load_i) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (run_i) begin
      if (match) begin
        cnt_d   = '0;
        acc_d   = acc_sum[DIV_FRAC_W-1:0];
        carry_d = acc_sum[DIV_FRAC_W];
      end else begin
        cnt_d = cnt_q + C_ONE;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/baud_tick_gen_frac.sv
`default_nettype none
// ============================================================================
//  Module   : baud_tick_gen_frac
//  Brief    : Fractional baud tick generator. Produces an oversample tick and
//             a bit tick from a programmable fixed-point divisor. New divisors
//             arrive over a valid/ready handshake and, while running, are held
//             in a shadow register until the next bit boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_INT_W    = 12,
  parameter int DIV_FRAC_W   = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int OS_W         = $clog2(OVERSAMPLE),
  parameter int RST_DIV_INT  = DEF_DIV_INT,
  parameter int RST_DIV_FRAC = DEF_DIV_FRAC
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  restart_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [DIV_INT_W-1:0]  cfg_div_int_i,
  input  logic [DIV_FRAC_W-1:0] cfg_div_frac_i,
  output logic                  cfg_err_o,
  output logic                  rx_tick_o,
  output logic                  tx_tick_o,
  output logic [OS_W-1:0]       os_phase_o
);

  localparam logic [DIV_INT_W-1:0]  C_RST_INT  = DIV_INT_W'(RST_DIV_INT);
  localparam logic [DIV_FRAC_W-1:0] C_RST_FRAC = DIV_FRAC_W'(RST_DIV_FRAC);
  localparam logic [DIV_INT_W-1:0]  C_MIN_DIV  = DIV_INT_W'(2);
  localparam logic [OS_W-1:0]       C_OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]       C_OS_ONE   = OS_W'(1);

  tick_state_e state_q, state_d;

  logic [DIV_INT_W-1:0]  act_int_q, act_int_d;
  logic [DIV_FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_INT_W-1:0]  shd_int_q, shd_int_d;
  logic [DIV_FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic [OS_W-1:0]       os_q, os_d, os_next;
  logic                  err_q, err_d;

  logic handshake;
  logic cfg_ok;
  logic accept;
  logic clear;
  logic run;
  logic div_tick;

  assign cfg_ready_o = (state_q != ST_PEND);
  assign handshake   = cfg_valid_i & cfg_ready_o;
  assign cfg_ok      = (cfg_div_int_i >= C_MIN_DIV);
  assign accept      = handshake & cfg_ok;
  assign run         = (state_q != ST_OFF);
  assign os_next     = (os_q == C_OS_LAST) ? '0 : (os_q + C_OS_ONE);

  // Both ticks decode registered state only; the divider gates on run.
  assign rx_tick_o  = div_tick;
  assign tx_tick_o  = div_tick & (os_q == C_OS_LAST);
  assign os_phase_o = os_q;
  assign cfg_err_o  = err_q;

  tick_frac_divider #(
    .DIV_INT_W  (DIV_INT_W),
    .DIV_FRAC_W (DIV_FRAC_W)
  ) u_div (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .run_i      (run),
    .load_i     (clear),
    .div_int_i  (act_int_q),
    .div_frac_i (act_frac_q),
    .rx_tick_o  (div_tick)
  );

  // Next state, divisor selection and phase counter. Any clear of the
  // counters also discards the tick decoded in that cycle: the phase goes
  // to 0 instead of advancing and the divider reloads.
  always_comb begin
    state_d    = state_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    os_d       = os_q;
    clear      = 1'b0;
    err_d      = handshake & ~cfg_ok;

    case (state_q)
      ST_OFF: begin
        clear = 1'b1;
        if (accept) begin
          act_int_d  = cfg_div_int_i;
          act_frac_d = cfg_div_frac_i;
        end
        if (en_i) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (!en_i || restart_i) begin
          // Counters restart, so a new divisor can take effect right away.
          clear = 1'b1;
          if (!en_i) state_d = ST_OFF;
          if (accept) begin
            act_int_d  = cfg_div_int_i;
            act_frac_d = cfg_div_frac_i;
          end
        end else begin
          if (accept) begin
            shd_int_d  = cfg_div_int_i;
            shd_frac_d = cfg_div_frac_i;
            state_d    = ST_PEND;
          end
          if (div_tick) os_d = os_next;
        end
      end

      ST_PEND: begin
        if (!en_i || restart_i || tx_tick_o) begin
          // Bit boundary (or forced re-phase): swap in the shadow divisor.
          clear      = 1'b1;
          act_int_d  = shd_int_q;
          act_frac_d = shd_frac_q;
          state_d    = en_i ? ST_RUN : ST_OFF;
        end else if (div_tick) begin
          os_d = os_next;
        end
      end

      default: begin
        clear   = 1'b1;
        state_d = ST_OFF;
      end
    endcase

    if (clear) os_d = '0;
  end

  // Controller state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_OFF;
      act_int_q  <= C_RST_INT;
      act_frac_q <= C_RST_FRAC;
      shd_int_q  <= C_RST_INT;
      shd_frac_q <= C_RST_FRAC;
      os_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      os_q       <= os_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire
